// File: rtl/i2c_target_register_port.sv
// rtl/i2c_target_register_port.sv - I2C target at a fixed address exposing an 8-bit register port
module i2c_target_register_port #(
    parameter logic [6:0] TARGET_ADDRESS = 7'h42
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_dir,
    output logic [7:0] reg_address,
    output logic [7:0] write_data,
    output logic       write_strobe,
    input  logic [7:0] read_data,
    output logic       read_strobe,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_rise_d, scl_fall_d, start_d, stop_d, sda_bit_d;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    state_t     state_d, state_q;
    logic [3:0] bit_cnt_d, bit_cnt_q;
    logic [7:0] shift_d, shift_q, shift_in;
    logic       rw_d, rw_q, got_ack_d, got_ack_q;
    logic       sda_dir_d, sda_dir_q, write_strobe_d, write_strobe_q;
    logic       read_strobe_d, read_strobe_q, busy_d, busy_q;
    logic [7:0] reg_address_d, reg_address_q, write_data_d, write_data_q;

    always_comb begin
        scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
        start_d    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
        stop_d     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
        sda_bit_d  = sda_sync_q[1];
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rw_d           = rw_q;
        got_ack_d      = got_ack_q;
        sda_dir_d      = sda_dir_q;
        reg_address_d  = reg_address_q;
        write_data_d   = write_data_q;
        write_strobe_d = 1'b0;
        read_strobe_d  = 1'b0;
        busy_d         = busy_q;
        shift_in       = {shift_q[6:0], sda_bit_q};
        if (start_q) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_dir_d = 1'b0;
        end else if (stop_q) begin
            state_d   = IDLE;
            sda_dir_d = 1'b0;
            busy_d    = 1'b0;
        end else if (read_strobe_q) begin
            // read_data was presented during the strobe cycle; bit 7 goes out now
            shift_d   = {read_data[6:0], 1'b0};
            sda_dir_d = ~read_data[7];
            bit_cnt_d = 4'd1;
            state_d   = RDATA;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise_q && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                if (shift_in[7:1] == TARGET_ADDRESS) begin
                                    busy_d = 1'b1;
                                    rw_d   = shift_in[0];
                                end else begin
                                    state_d = IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == PTR) begin
                                reg_address_d = shift_in;
                            end else begin
                                write_data_d   = shift_in;
                                write_strobe_d = 1'b1;
                            end
                        end
                    end else if (scl_fall_q && bit_cnt_q == 4'd8) begin
                        sda_dir_d = 1'b1;
                        state_d   = (state_q == ADDR) ? ADDR_ACK :
                                    (state_q == PTR)  ? PTR_ACK  : WDATA_ACK;
                    end
                end
                ADDR_ACK: if (scl_fall_q) begin
                    sda_dir_d = 1'b0;
                    bit_cnt_d = 4'd0;
                    if (rw_q) read_strobe_d = 1'b1;
                    else      state_d       = PTR;
                end
                PTR_ACK: if (scl_fall_q) begin
                    sda_dir_d = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = WDATA;
                end
                WDATA_ACK: if (scl_fall_q) begin
                    sda_dir_d     = 1'b0;
                    bit_cnt_d     = 4'd0;
                    reg_address_d = reg_address_q + 8'd1;
                    state_d       = WDATA;
                end
                RDATA: if (scl_fall_q) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_dir_d = 1'b0;
                        got_ack_d = 1'b0;
                        state_d   = RACK;
                    end else begin
                        sda_dir_d = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                RACK: begin
                    if (scl_rise_q) begin
                        if (!sda_bit_q) begin
                            reg_address_d = reg_address_q + 8'd1;
                            got_ack_d     = 1'b1;
                        end else begin
                            state_d   = IGNORE;
                            busy_d    = 1'b0;
                            sda_dir_d = 1'b0;
                        end
                    end else if (scl_fall_q && got_ack_q) begin
                        read_strobe_d = 1'b1;
                        got_ack_d     = 1'b0;
                    end
                end
                default: sda_dir_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync_q     <= 3'b111;
            sda_sync_q     <= 3'b111;
            scl_rise_q     <= 1'b0;
            scl_fall_q     <= 1'b0;
            start_q        <= 1'b0;
            stop_q         <= 1'b0;
            sda_bit_q      <= 1'b1;
            state_q        <= IDLE;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 8'd0;
            rw_q           <= 1'b0;
            got_ack_q      <= 1'b0;
            sda_dir_q      <= 1'b0;
            reg_address_q  <= 8'd0;
            write_data_q   <= 8'd0;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            scl_sync_q     <= {scl_sync_q[1:0], scl_in};
            sda_sync_q     <= {sda_sync_q[1:0], sda_in};
            scl_rise_q     <= scl_rise_d;
            scl_fall_q     <= scl_fall_d;
            start_q        <= start_d;
            stop_q         <= stop_d;
            sda_bit_q      <= sda_bit_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rw_q           <= rw_d;
            got_ack_q      <= got_ack_d;
            sda_dir_q      <= sda_dir_d;
            reg_address_q  <= reg_address_d;
            write_data_q   <= write_data_d;
            write_strobe_q <= write_strobe_d;
            read_strobe_q  <= read_strobe_d;
            busy_q         <= busy_d;
        end
    end

    assign sda_out      = 1'b0;
    assign sda_dir      = sda_dir_q;
    assign reg_address  = reg_address_q;
    assign write_data   = write_data_q;
    assign write_strobe = write_strobe_q;
    assign read_strobe  = read_strobe_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_i2c_target_register_port.sv
// tb/tb_i2c_target_register_port.sv - bit-banged I2C initiator bench for i2c_target_register_port
module tb_i2c_target_register_port;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_out, sda_dir, write_strobe, read_strobe, busy;
    logic [7:0] reg_address, write_data, read_data;
    logic       bus_sda;

    int n_cmp = 0;
    int n_fail = 0;
    int ws_cnt = 0;
    int rs_cnt = 0;
    logic dir_seen = 1'b0;
    logic busy_seen = 1'b0;
    logic [7:0] wlog_a[$];
    logic [7:0] wlog_d[$];
    logic [7:0] fab_mem[256];
    logic [7:0] model_mem[256];

    always #5 clock = ~clock;

    assign bus_sda   = sda_m & ~sda_dir;
    assign read_data = fab_mem[reg_address];

    i2c_target_register_port dut (
        .clock(clock), .reset(reset), .scl_in(scl_m), .sda_in(bus_sda),
        .sda_out(sda_out), .sda_dir(sda_dir), .reg_address(reg_address),
        .write_data(write_data), .write_strobe(write_strobe), .read_data(read_data),
        .read_strobe(read_strobe), .busy(busy)
    );

    // Fabric side: a register file that absorbs write strobes
    always @(negedge clock) begin
        if (write_strobe) begin
            ws_cnt++;
            wlog_a.push_back(reg_address);
            wlog_d.push_back(write_data);
            fab_mem[reg_address] = write_data;
        end
        if (read_strobe) rs_cnt++;
        if (sda_dir) dir_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_bit(input logic b, output logic rb);
        wait_clk(10); sda_m = b;
        wait_clk(10); scl_m = 1'b1;
        wait_clk(10); rb = bus_sda;
        wait_clk(10); scl_m = 1'b0;
    endtask

    task automatic i2c_start;
        wait_clk(10); sda_m = 1'b1;
        wait_clk(10); scl_m = 1'b1;
        wait_clk(10); sda_m = 1'b0;
        wait_clk(10); scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_clk(10); sda_m = 1'b0;
        wait_clk(10); scl_m = 1'b1;
        wait_clk(10); sda_m = 1'b1;
        wait_clk(20);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(~mack, r);
    endtask

    task automatic clear_logs;
        ws_cnt = 0; rs_cnt = 0; dir_seen = 1'b0; busy_seen = 1'b0;
        wlog_a.delete(); wlog_d.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clk(5);
        n_cmp++;
        if ({sda_out, sda_dir, reg_address, write_data, write_strobe, read_strobe, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_values: got out=%b dir=%b ptr=%h wd=%h ws=%b rs=%b busy=%b want all 0",
                     sda_out, sda_dir, reg_address, write_data, write_strobe, read_strobe, busy);
        end
        reset = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_write;
        logic [7:0] bytes [4];
        logic ack;
        bytes = '{8'h84, 8'h10, 8'hA5, 8'h3C};
        clear_logs();
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ack);
            n_cmp++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL write_ack%0d: got %b want 1", i, ack); end
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_during: got %b want 1", busy); end
        i2c_stop();
        model_mem[8'h10] = 8'hA5;
        model_mem[8'h11] = 8'h3C;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
        n_cmp++;
        if (wlog_a.size() != 2) begin
            n_fail++; $display("FAIL write_strobe_count: got %0d want 2", wlog_a.size());
        end else if ({wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1]} !== 32'h10A5_113C) begin
            n_fail++;
            $display("FAIL write_pairs: got (%h,%h) (%h,%h) want (10,a5) (11,3c)",
                     wlog_a[0], wlog_d[0], wlog_a[1], wlog_d[1]);
        end
    endtask

    task automatic test_read;
        logic ack;
        logic [7:0] d;
        logic [7:0] exp [3];
        exp = '{8'h01, 8'h00, 8'hFF};
        clear_logs();
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'hFE, ack);
        i2c_start();
        send_byte(8'h85, ack);
        n_cmp++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b want 1", ack); end
        for (int i = 0; i < 3; i++) begin
            recv_byte(i < 2, d);
            n_cmp++;
            if (d !== exp[i]) begin n_fail++; $display("FAIL read_byte%0d: got %h want %h", i, d, exp[i]); end
        end
        wait_clk(20);
        n_cmp++;
        if (sda_dir !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL read_nack_release: got dir=%b busy=%b want 0 0", sda_dir, busy);
        end
        n_cmp++;
        if (reg_address !== 8'h00) begin n_fail++; $display("FAIL read_ptr_wrap: got %h want 00", reg_address); end
        n_cmp++;
        if (rs_cnt != 3) begin n_fail++; $display("FAIL read_strobe_count: got %0d want 3", rs_cnt); end
        i2c_stop();
    endtask

    task automatic test_wrong_addr;
        logic ack0, ack1;
        clear_logs();
        i2c_start();
        send_byte(8'h90, ack0);
        send_byte(8'($urandom), ack1);
        i2c_stop();
        n_cmp++;
        if ({ack0, ack1, dir_seen, busy_seen} !== 4'b0000 || ws_cnt != 0 || rs_cnt != 0) begin
            n_fail++;
            $display("FAIL wrong_addr: got ack=%b%b dir_seen=%b busy_seen=%b ws=%0d rs=%0d want all 0",
                     ack0, ack1, dir_seen, busy_seen, ws_cnt, rs_cnt);
        end
    endtask

    task automatic test_stop_mid_byte;
        logic ack, r;
        logic [7:0] p, q, d;
        p = 8'($urandom_range(8'h30, 8'h7F));
        q = 8'($urandom_range(8'h30, 8'h7F));
        d = 8'($urandom);
        clear_logs();
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(p, ack);
        for (int i = 0; i < 4; i++) i2c_bit(1'($urandom), r);
        i2c_stop();
        n_cmp++;
        if (ws_cnt != 0 || busy !== 1'b0 || sda_dir !== 1'b0) begin
            n_fail++; $display("FAIL stop_mid_byte: got ws=%0d busy=%b dir=%b want 0 0 0", ws_cnt, busy, sda_dir);
        end
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(q, ack);
        send_byte(d, ack);
        i2c_stop();
        model_mem[q] = d;
        n_cmp++;
        if (ack !== 1'b1 || wlog_a.size() != 1) begin
            n_fail++; $display("FAIL after_stop_write: got ack=%b strobes=%0d want 1 1", ack, wlog_a.size());
        end else if (wlog_a[0] !== q || wlog_d[0] !== d) begin
            n_fail++; $display("FAIL after_stop_pair: got (%h,%h) want (%h,%h)", wlog_a[0], wlog_d[0], q, d);
        end
    endtask

    task automatic test_rep_start;
        logic ack;
        logic [7:0] d;
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'h20, ack);
        i2c_start();
        send_byte(8'h85, ack);
        recv_byte(1'b1, d);
        n_cmp++;
        if (d !== model_mem[8'h20]) begin n_fail++; $display("FAIL rep_first: got %h want %h", d, model_mem[8'h20]); end
        i2c_start();
        n_cmp++;
        if (reg_address !== 8'h21) begin n_fail++; $display("FAIL rep_ptr: got %h want 21", reg_address); end
        send_byte(8'h85, ack);
        recv_byte(1'b0, d);
        n_cmp++;
        if (ack !== 1'b1 || d !== model_mem[8'h21]) begin
            n_fail++; $display("FAIL rep_restart: got ack=%b data=%h want 1 %h", ack, d, model_mem[8'h21]);
        end
        i2c_stop();
    endtask

    task automatic test_reset_mid_read;
        logic ack;
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'hC3, ack);
        i2c_start();
        send_byte(8'h85, ack);
        wait_clk(8);
        n_cmp++;
        if (sda_dir !== 1'b1) begin n_fail++; $display("FAIL rst_pre_drive: got %b want 1", sda_dir); end
        reset = 1'b1;
        wait_clk(1);
        n_cmp++;
        if ({sda_out, sda_dir, reg_address, write_data, write_strobe, read_strobe, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_mid_read: got dir=%b ptr=%h wd=%h ws=%b rs=%b busy=%b want all 0",
                     sda_dir, reg_address, write_data, write_strobe, read_strobe, busy);
        end
        reset = 1'b0;
        i2c_stop();
    endtask

    task automatic test_random;
        logic ack;
        logic [7:0] p, d;
        logic [7:0] data[$];
        int n;
        for (int it = 0; it < 3; it++) begin
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            data.delete();
            clear_logs();
            i2c_start();
            send_byte(8'h84, ack);
            send_byte(p, ack);
            for (int i = 0; i < n; i++) begin
                data.push_back(8'($urandom));
                send_byte(data[i], ack);
                model_mem[8'(p + i)] = data[i];
            end
            i2c_stop();
            n_cmp++;
            if (ack !== 1'b1 || wlog_a.size() != n) begin
                n_fail++; $display("FAIL rand_write%0d: got ack=%b strobes=%0d want 1 %0d", it, ack, wlog_a.size(), n);
            end
            i2c_start();
            send_byte(8'h84, ack);
            send_byte(p, ack);
            i2c_start();
            send_byte(8'h85, ack);
            for (int i = 0; i < n; i++) begin
                recv_byte(i < n - 1, d);
                n_cmp++;
                if (d !== model_mem[8'(p + i)]) begin
                    n_fail++; $display("FAIL rand_read%0d_%0d: got %h want %h", it, i, d, model_mem[8'(p + i)]);
                end
            end
            i2c_stop();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            fab_mem[i]   = ~8'(i);
            model_mem[i] = ~8'(i);
        end
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_stop_mid_byte();
        test_rep_start();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_target_register_port.md
# i2c_target_register_port

I2C target (responder) that answers at one fixed 7-bit address and exposes an 8-bit-addressed register space to the fabric. It is the far end of our I2C initiator modules: it decodes START/STOP, matches the address byte and ACKs it. A write loads a register pointer and then writes data bytes. A read returns bytes from fabric-supplied data. The pointer auto-increments after every data byte.

## Interface
- TARGET_ADDRESS, 7'h42, 7-bit address this target ACKs; every other address, including 7'h00, is ignored.
- clock  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  synchronous, active-high.
- scl_in  input  1  raw SCL pin level, asynchronous.
- sda_in  input  1  raw SDA pin level, asynchronous.
- sda_out  output  1  always 0; pad drives sda_out when sda_dir=1 (open-drain emulation).
- sda_dir  output  1  1 = pull SDA low, 0 = release.
- reg_address  output  8  current register pointer.
- write_data  output  8  last received data byte; valid while write_strobe=1.
- write_strobe  output  1  one-cycle pulse: write write_data to reg_address.
- read_data  input  8  fabric data for reg_address; sampled on the read_strobe cycle.
- read_strobe  output  1  one-cycle pulse: read_data is captured that cycle.
- busy  output  1  1 from the detected START addressing this target until STOP or leaving the transaction.

## Operation
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - Events are decoded from the synchronized values:
    - scl_rise / scl_fall: SCL edge.
    - START: SDA 1->0 while SCL=1.
    - STOP: SDA 0->1 while SCL=1.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- Global transitions, from any state:
  - START -> ADDR; bit count cleared; sda_dir=0.
  - STOP -> IDLE; sda_dir=0; busy=0.
  - Repeated START keeps reg_address unchanged.
- Receive bytes (ADDR, PTR, WDATA): shift the synchronized SDA in MSB-first on each scl_rise; the 8th bit completes the byte.
- ADDR:
  - Bits [7:1] == TARGET_ADDRESS: busy=1; on the next scl_fall set sda_dir=1 (ACK) and go to ADDR_ACK.
  - Otherwise: go to IGNORE, no ACK.
- ADDR_ACK, released on the scl_fall ending the ACK clock:
  - R/W=0: release SDA, go to PTR.
  - R/W=1: pulse read_strobe, load the shift register from read_data, drive bit 7, go to RDATA.
- PTR: byte goes to reg_address; ACK as above; then WDATA.
- WDATA: byte goes to write_data; write_strobe pulses on the cycle the 8th bit is sampled; ACK; in WDATA_ACK the pointer increments when ACK is released; back to WDATA.
- RDATA:
  - On each scl_fall: sda_dir = ~current bit (drive low for 0, release for 1), then shift.
  - After the 8th bit's scl_fall: release SDA and go to RACK.
- RACK: sample SDA on scl_rise.
  - SDA=0 (initiator ACK): increment the pointer. On the next scl_fall pulse read_strobe, load read_data, drive bit 7, go to RDATA.
  - SDA=1 (NACK): go to IGNORE with SDA released.
- IGNORE: SDA stays released until START or STOP.
- Pointer arithmetic: 8-bit, wraps 8'hFF -> 8'h00.

## Timing
- Reset values: sda_out=0, sda_dir=0, reg_address=0, write_data=0, write_strobe=0, read_strobe=0, busy=0, state IDLE.
- Reset asserted mid-transfer: SDA released on the cycle after reset is sampled.
- Event latency: pin change to event decode is 3 clocks. SDA drive changes 4 clocks after the actual SCL fall; this is the hold time relative to SCL.
- write_strobe: 4 clocks after the SCL rise of data bit 0.
- read_strobe: on the drive cycle of bit 7. read_data must be valid on that cycle; reg_address is stable for at least 1 clock before it.
- START and scl_fall in the same cycle: START wins.
- STOP during ACK drive: SDA released in the same cycle as the STOP decode.

## Test plan
- Write with SCL period 40 clocks: START, 0x84 (addr 0x42, W), 0x10, 0xA5, 0x3C, STOP. Required: ACK on all 4 bytes; write_strobe pulses with (reg_address, write_data) = (0x10, 0xA5) then (0x11, 0x3C); busy falls after STOP.
- Read:
  - Write pointer 0xFE, repeated START, 0x85, master ACK, ACK, NACK.
  - read_data is supplied as ~reg_address.
  - Required: bytes 0x01, 0x00, 0xFF on SDA; pointer wraps 0xFF -> 0x00; SDA released after the NACK.
- Wrong address 0x90 followed by a data byte: sda_dir stays 0 throughout; no strobes; busy stays 0.
- STOP mid-byte after 4 data bits of WDATA: no write_strobe; state IDLE; next valid write works normally.
- Reset asserted while the target is driving a 0 read bit: sda_dir=0 on the next cycle and all outputs at reset values.
- Repeated START mid-read: returns to ADDR; reg_address is unchanged; the next read restarts from the current pointer.
